// File: rtl/t05_huff_pkg.sv
// rtl/t05_huff_pkg.sv - shared state encoding and element field constants for the Huffman decoder
package t05_huff_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_EL,
      WAIT_BIT,
      EMIT,
      DONE,
      ERR
   } hdec_state_t;

   localparam logic [8:0] NODE_NULL    = 9'h180;
   localparam int         NODE_SUM_BIT = 8;
   localparam int         L1_MSB       = 63;
   localparam int         L1_LSB       = 55;
   localparam int         L2_MSB       = 54;
   localparam int         L2_LSB       = 46;
   localparam logic [3:0] FINISH_OK    = 4'b0101;
   localparam logic [3:0] FINISH_ERR   = 4'b1111;

endpackage

// File: rtl/t05_huff_decode.sv
// rtl/t05_huff_decode.sv - serial Huffman tree walker: one bit per edge, one char per leaf
module t05_huff_decode
   import t05_huff_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MAX_DEPTH = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       max_index,
   input  logic [CNT_W-1:0] total_chars,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic             htree_req,
   output logic [6:0]       htree_index,
   input  logic [70:0]      h_element,
   input  logic             htree_ack,
   output logic [7:0]       char_out,
   output logic             char_valid,
   input  logic             char_ready,
   output logic [CNT_W-1:0] chars_done,
   output logic             busy,
   output logic [3:0]       finished
);

   hdec_state_t      state;
   logic [6:0]       root;
   logic [6:0]       node_idx;
   logic [6:0]       depth;
   logic [CNT_W-1:0] total;
   logic [8:0]       least1;
   logic [8:0]       least2;
   logic [8:0]       child;
   logic             depth_over;
   logic [CNT_W-1:0] done_inc;
   logic             unused_elem_bits;

   assign child      = bit_in ? least2 : least1;
   // depth is widened so the comparison happens before the 7-bit increment can wrap
   assign depth_over = ({1'b0, depth} + 8'd1) > 8'(MAX_DEPTH);
   assign done_inc   = chars_done + CNT_W'(1);
   assign unused_elem_bits = ^{h_element[70:64], h_element[45:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         root        <= '0;
         node_idx    <= '0;
         depth       <= '0;
         total       <= '0;
         least1      <= '0;
         least2      <= '0;
         bit_ready   <= 1'b0;
         htree_req   <= 1'b0;
         htree_index <= '0;
         char_out    <= '0;
         char_valid  <= 1'b0;
         chars_done  <= '0;
         busy        <= 1'b0;
         finished    <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  root       <= max_index;
                  node_idx   <= max_index;
                  total      <= total_chars;
                  chars_done <= '0;
                  depth      <= '0;
                  if (total_chars == '0) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     finished <= FINISH_OK;
                  end else begin
                     state    <= FETCH;
                     busy     <= 1'b1;
                     finished <= '0;
                  end
               end
            end
            FETCH: begin
               htree_req   <= 1'b1;
               htree_index <= node_idx;
               state       <= WAIT_EL;
            end
            WAIT_EL: begin
               if (htree_ack) begin
                  least1    <= h_element[L1_MSB:L1_LSB];
                  least2    <= h_element[L2_MSB:L2_LSB];
                  htree_req <= 1'b0;
                  bit_ready <= 1'b1;
                  state     <= WAIT_BIT;
               end
            end
            WAIT_BIT: begin
               if (bit_valid && bit_ready) begin
                  bit_ready <= 1'b0;
                  depth     <= depth + 7'd1;
                  if (depth_over || child == NODE_NULL) begin
                     state    <= ERR;
                     busy     <= 1'b0;
                     finished <= FINISH_ERR;
                  end else if (child[NODE_SUM_BIT]) begin
                     node_idx <= child[6:0];
                     state    <= FETCH;
                  end else begin
                     char_out   <= child[7:0];
                     char_valid <= 1'b1;
                     state      <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (char_ready) begin
                  char_valid <= 1'b0;
                  chars_done <= done_inc;
                  depth      <= '0;
                  if (done_inc == total) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     finished <= FINISH_OK;
                  end else begin
                     node_idx <= root;
                     state    <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
